mmio_responder: RTL and testbench
=================================

# mmio_responder

Device-side responder for the memory stage's MMIO port. It decodes `io_addr` / `io_we` / `io_rd` and holds the board's output registers: 16 LEDs and the 32-bit seven-segment value, with an output-ready handshake. It captures switch input through a debounced button with an input-valid handshake, and provides a free-running cycle counter. Read data returns combinationally on `io_din` in the same cycle, as the memory stage muxes it into its load result without a wait state.

## Interface
Parameters:
- `DB_CYCLES`, 1000000, cycles `btn` must stay stable before the debounced level changes (≥1)
- `HOLD_CYCLES`, 4, cycles `out_ready` stays low after an accepted seven-seg write (≥1)

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- `io_addr`  in  8  byte address of MMIO access
- `io_dout`  in  32  CPU write data
- `io_we`  in  1  write strobe, single cycle per store
- `io_rd`  in  1  read strobe, single cycle per load
- `io_din`  out  32  read data to CPU, combinational
- `sw`  in  16  board switches, asynchronous
- `btn`  in  1  "enter" button, asynchronous, active-high
- `led`  out  16  LED register
- `seg_data`  out  32  seven-seg display value
- `seg_upd`  out  1  one-cycle pulse when `seg_data` is updated

## Operation
Address map; unmapped reads return 0, unmapped writes are ignored:
- 0x00 W: `led` <= `io_dout[15:0]`
- 0x04 R: {31'b0, `out_ready`}
- 0x08 W: if `out_ready`=1, `seg_data` <= `io_dout`, pulse `seg_upd`, `out_ready` <= 0, hold counter <= HOLD_CYCLES. If `out_ready`=0, the write is dropped with no state change.
- 0x0C R: {31'b0, `in_valid`}
- 0x10 R: {16'b0, `in_data`}; with `io_rd`=1, clears `in_valid` at the next edge
- 0x14 R: 32-bit cycle counter

Output path:
- Hold counter decrements while `out_ready`=0.
- `out_ready` returns to 1 on the edge where the counter reaches 0.

Input path:
- `btn` passes through a 2-FF synchronizer.
- Debounce counter resets on any mismatch between the synchronized value and the debounced level. After DB_CYCLES consecutive matching-mismatch cycles, the debounced level flips.
- Rising edge of the debounced level (registered previous value) forms the press event.
- Press with `in_valid`=0: `in_data` <= synchronized `sw`, `in_valid` <= 1.
- Press with `in_valid`=1 and no clearing read that cycle: press is dropped; `in_data` is unchanged.
- Press in the same cycle as a clearing read of 0x10: the capture wins, `in_data` takes the new value, and `in_valid` stays 1. The read returns the old data.

Strobes and side effects:
- `io_din` is driven from `io_addr` regardless of `io_rd`.
- Only the 0x10 read has a side effect, and only when `io_rd`=1.
- `io_we` and `io_rd` both high: write and read effects apply independently.

Cycle counter:
- Increments every cycle and wraps 0xFFFFFFFF → 0.

## Timing
- Reset values (sampled at the `rstn`=0 edge): `led`=0, `seg_data`=0, `seg_upd`=0, `out_ready`=1, `in_valid`=0, `in_data`=0, counter=0, hold counter=0, debounce state=0, synchronizers=0.
- Reset mid-hold or mid-debounce aborts the operation; nothing is pending afterwards.
- Writes take effect at the edge ending the strobe cycle; `seg_upd` is high the following cycle only.
- Accepted seven-seg write at edge T: `out_ready`=0 for cycles T..T+HOLD_CYCLES-1, reads 1 from T+HOLD_CYCLES.
- Press latency from a clean `btn` rise to `in_valid`=1: 2 (sync) + DB_CYCLES + 1 cycles.
- Read data valid in the same cycle as `io_addr`; no wait states.
- Counter read returns the value before that cycle's increment.

## Test plan
- Reset then read 0x00..0x14 → `led`=0, `seg_data`=0, 0x04 reads 1, 0x0C reads 0, 0x10 reads 0.
- Write 0x1234ABCD to 0x08, then again the next cycle, with HOLD_CYCLES=4 → `seg_data`=0x1234ABCD, one `seg_upd` pulse, second write dropped, 0x04 reads 0 for 4 cycles then 1.
- DB_CYCLES=4; `sw`=0x00A5; `btn` high 2 cycles (glitch) then high 10 cycles → glitch ignored, `in_valid`=1 exactly 7 cycles after the stable rise, 0x10 reads 0x000000A5.
- Set `in_valid`, change `sw` to 0x0F0F, second press → data remains 0x00A5. Read 0x10 → returns 0x00A5, `in_valid`=0 next cycle.
- Align a press (`sw`=0x5555) with a clearing read of 0x10 → read returns old data, `in_valid` stays 1, next read returns 0x5555.
- Write 0xFFFF_00FF to 0x00 and read 0x20 → `led`=0x00FF, `io_din`=0. Reset during hold → `out_ready`=1 after reset.

Source files
------------

// File: rtl/mmio_responder.sv
// MMIO device responder: LED and seven-seg output registers with a ready/hold
// handshake, a debounced button capture of switches, and a free-running cycle counter.
module mmio_responder #(
  parameter int DB_CYCLES   = 1000000,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [31:0] seg_data,
  output logic        seg_upd
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [7:0] ADDR_LED    = 8'h00;
  localparam logic [7:0] ADDR_ORDY   = 8'h04;
  localparam logic [7:0] ADDR_SEG    = 8'h08;
  localparam logic [7:0] ADDR_IVALID = 8'h0C;
  localparam logic [7:0] ADDR_IDATA  = 8'h10;
  localparam logic [7:0] ADDR_CYCLE  = 8'h14;

  logic [15:0]       r_led;
  logic [31:0]       r_seg_data;
  logic              r_seg_upd;
  logic              r_out_ready;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_in_valid;
  logic [15:0]       r_in_data;
  logic [31:0]       r_cycle;
  logic              r_btn_s1;
  logic              r_btn_s2;
  logic [15:0]       r_sw_s1;
  logic [15:0]       r_sw_s2;
  logic              r_db_level;
  logic              r_db_prev;
  logic [DB_W-1:0]   r_db_cnt;

  logic w_seg_accept;
  logic w_clear_rd;
  logic w_press;

  assign w_seg_accept = io_we && (io_addr == ADDR_SEG) && r_out_ready;
  assign w_clear_rd   = io_rd && (io_addr == ADDR_IDATA);
  assign w_press      = r_db_level && !r_db_prev;

  assign led      = r_led;
  assign seg_data = r_seg_data;
  assign seg_upd  = r_seg_upd;

  // Read path is combinational so the memory stage sees data with no wait state.
  always_comb begin
    io_din = 32'h0;
    case (io_addr)
      ADDR_ORDY:   io_din = {31'h0, r_out_ready};
      ADDR_IVALID: io_din = {31'h0, r_in_valid};
      ADDR_IDATA:  io_din = {16'h0, r_in_data};
      ADDR_CYCLE:  io_din = r_cycle;
      default:     io_din = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_led       <= 16'h0;
      r_seg_data  <= 32'h0;
      r_seg_upd   <= 1'b0;
      r_out_ready <= 1'b1;
      r_hold_cnt  <= '0;
    end else begin
      r_seg_upd <= w_seg_accept;
      if (io_we && (io_addr == ADDR_LED)) begin
        r_led <= io_dout[15:0];
      end
      if (w_seg_accept) begin
        r_seg_data  <= io_dout;
        r_out_ready <= 1'b0;
        r_hold_cnt  <= HOLD_W'(HOLD_CYCLES);
      end else if (!r_out_ready) begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        if (r_hold_cnt == HOLD_W'(1)) begin
          r_out_ready <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_sw_s1  <= 16'h0;
      r_sw_s2  <= 16'h0;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Level flips only after DB_CYCLES consecutive cycles disagreeing with it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_db_prev <= r_db_level;
      if (r_btn_s2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
        r_db_cnt   <= '0;
        r_db_level <= ~r_db_level;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // A press coinciding with a clearing read wins: new data lands, valid stays set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_in_valid <= 1'b0;
      r_in_data  <= 16'h0;
    end else if (w_press && (!r_in_valid || w_clear_rd)) begin
      r_in_valid <= 1'b1;
      r_in_data  <= r_sw_s2;
    end else if (w_clear_rd) begin
      r_in_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cycle <= 32'h0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with DB_CYCLES=4 and HOLD_CYCLES=4.
`timescale 1ns/1ps
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] led;
  logic [31:0] seg_data;
  logic        seg_upd;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mmio_responder #(.DB_CYCLES(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .io_addr(io_addr), .io_dout(io_dout),
    .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .sw(sw), .btn(btn),
    .led(led), .seg_data(seg_data), .seg_upd(seg_upd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // Drive a read for one cycle, compare io_din mid-cycle, then advance.
  task automatic rd(input string tag, input logic [7:0] a, input logic strobe,
                    input logic [31:0] e);
    io_addr = a;
    io_rd   = strobe;
    expect_val(e);
    @(negedge clk);
    chk(tag, io_din);
    step();
    io_rd = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we   = 1'b1;
    step();
    io_we   = 1'b0;
  endtask

  task automatic btn_pulse();
    btn = 1'b1;
    repeat (10) step();
    btn = 1'b0;
    repeat (12) step();
  endtask

  initial begin
    rstn = 1'b0; io_addr = 8'h00; io_dout = 32'h0; io_we = 1'b0; io_rd = 1'b0;
    sw = 16'h0; btn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;

    // Reset state and counter start
    io_addr = 8'h14;
    expect_val(32'h0); expect_val(32'h0); expect_val(32'h0); expect_val(32'h0);
    @(negedge clk);
    chk("rst_led", {16'h0, led});
    chk("rst_seg_data", seg_data);
    chk("rst_seg_upd", {31'h0, seg_upd});
    chk("rst_cycle0", io_din);
    step();
    expect_val(32'h1);
    @(negedge clk);
    chk("cycle1", io_din);
    step();
    rd("rd_00", 8'h00, 1'b1, 32'h0);
    rd("rd_04", 8'h04, 1'b1, 32'h1);
    rd("rd_08", 8'h08, 1'b1, 32'h0);
    rd("rd_0c", 8'h0C, 1'b1, 32'h0);
    rd("rd_10", 8'h10, 1'b1, 32'h0);

    // Seven-seg write accepted, back-to-back write dropped, ready hold
    io_addr = 8'h08; io_dout = 32'h1234ABCD; io_we = 1'b1;
    step();
    io_dout = 32'hDEADBEEF;
    expect_val(32'h1); expect_val(32'h1234ABCD);
    @(negedge clk);
    chk("seg_upd_pulse", {31'h0, seg_upd});
    chk("seg_data_wr", seg_data);
    step();
    io_we = 1'b0;
    io_addr = 8'h04;
    expect_val(32'h0); expect_val(32'h1234ABCD); expect_val(32'h0);
    @(negedge clk);
    chk("seg_upd_low", {31'h0, seg_upd});
    chk("seg_data_kept", seg_data);
    chk("ordy_t1", io_din);
    step();
    rd("ordy_t2", 8'h04, 1'b0, 32'h0);
    rd("ordy_t3", 8'h04, 1'b0, 32'h0);
    rd("ordy_t4", 8'h04, 1'b0, 32'h1);

    // Glitch then clean press with sw=0x00A5
    sw = 16'h00A5;
    repeat (4) step();
    btn = 1'b1;
    step(); step();
    btn = 1'b0;
    for (int i = 0; i < 8; i++) rd("glitch_ivalid", 8'h0C, 1'b0, 32'h0);
    btn = 1'b1;
    io_addr = 8'h0C;
    for (int i = 0; i < 6; i++) begin
      step();
      expect_val(32'h0);
      @(negedge clk);
      chk("press_wait", io_din);
    end
    step();
    expect_val(32'h1);
    @(negedge clk);
    chk("press_lat7", io_din);
    repeat (4) step();
    btn = 1'b0;
    repeat (10) step();
    rd("idata_a5", 8'h10, 1'b0, 32'h000000A5);

    // Press while valid is dropped; clearing read
    sw = 16'h0F0F;
    repeat (3) step();
    btn_pulse();
    rd("ivalid_held", 8'h0C, 1'b0, 32'h1);
    rd("idata_kept", 8'h10, 1'b0, 32'h000000A5);
    rd("idata_clr", 8'h10, 1'b1, 32'h000000A5);
    rd("ivalid_clr", 8'h0C, 1'b0, 32'h0);

    // Press aligned with clearing read
    sw = 16'h1111;
    repeat (3) step();
    btn_pulse();
    rd("idata_1111", 8'h10, 1'b0, 32'h00001111);
    sw = 16'h5555;
    repeat (3) step();
    btn = 1'b1;
    repeat (6) step();
    rd("race_old", 8'h10, 1'b1, 32'h00001111);
    rd("race_valid", 8'h0C, 1'b0, 32'h1);
    rd("race_new", 8'h10, 1'b0, 32'h00005555);
    btn = 1'b0;
    repeat (10) step();

    // LED write, unmapped read and write
    wr(8'h00, 32'hFFFF00FF);
    expect_val(32'h000000FF);
    @(negedge clk);
    chk("led_wr", {16'h0, led});
    step();
    rd("unmapped_rd", 8'h20, 1'b0, 32'h0);
    rd("unmapped_18", 8'h18, 1'b0, 32'h0);
    wr(8'h20, 32'h12345678);
    expect_val(32'h000000FF); expect_val(32'h1234ABCD);
    @(negedge clk);
    chk("led_unmapped", {16'h0, led});
    chk("seg_unmapped", seg_data);
    step();

    // Reset during hold
    wr(8'h08, 32'hCAFEF00D);
    io_addr = 8'h04;
    expect_val(32'hCAFEF00D); expect_val(32'h0);
    @(negedge clk);
    chk("seg_wr2", seg_data);
    chk("ordy_hold2", io_din);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    expect_val(32'h1); expect_val(32'h0); expect_val(32'h0);
    @(negedge clk);
    chk("ordy_after_rst", io_din);
    chk("seg_after_rst", seg_data);
    chk("led_after_rst", {16'h0, led});
    step();
    wr(8'h08, 32'h0BADF00D);
    expect_val(32'h0BADF00D); expect_val(32'h1);
    @(negedge clk);
    chk("seg_wr_post_rst", seg_data);
    chk("seg_upd_post_rst", {31'h0, seg_upd});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
